// File: rtl/rvfi_env_pkg.sv
// Shared helpers for the RVFI formal memory environment: lane merge and
// width helpers used to derive NB and CNT_W inside the modules.
package rvfi_env_pkg;

  function automatic int calc_nb(input int data_w);
    return data_w / 8;
  endfunction

  // A zero-width counter is illegal, so MAX_STALL=0 still reports 1 bit.
  function automatic int calc_cnt_w(input int max_stall);
    return (max_stall < 1) ? 1 : $clog2(max_stall + 1);
  endfunction

  function automatic logic [7:0] merge(input logic [7:0] shadow,
                                       input logic [7:0] rnd,
                                       input logic       bvalid);
    return bvalid ? shadow : rnd;
  endfunction

endpackage

// File: rtl/rvfi_stall_limiter.sv
// Bounds a solver-driven stall request to at most MAX_STALL consecutive
// cycles; stall is forced high and saturation low while in reset.
module rvfi_stall_limiter
  import rvfi_env_pkg::*;
#(
  parameter int MAX_STALL = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic stall_rnd,
  output logic stall,
  output logic sat
);

  logic grant;

  generate
    if (MAX_STALL == 0) begin : g_never
      logic unused_clk;
      assign unused_clk = clock;
      assign grant      = 1'b0;
    end else begin : g_cnt
      localparam int CNT_W = calc_cnt_w(MAX_STALL);

      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;
      logic             grant_c;

      // NOTE: every signal written here gets a value on every path first,
      // otherwise always_comb would have to hold state and infer a latch.
      always_comb begin
        grant_c = stall_rnd && (cnt_q < CNT_W'(MAX_STALL));
        cnt_d   = grant_c ? cnt_q + CNT_W'(1) : '0;
      end

      // NOTE: state updates use non-blocking assignment so every flop samples
      // its pre-edge inputs regardless of statement or process order.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign grant = grant_c;
    end
  endgenerate

  assign stall = !reset_n || grant;
  assign sat   = reset_n && stall_rnd && !grant;

endmodule

// File: rtl/rvfi_mem_env.sv
// Constrained imem/dmem responder: bounded stalls plus a byte-granular shadow
// of solver-chosen word addresses so reads return what the hart last wrote.
module rvfi_mem_env
  import rvfi_env_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_STALL = 4,
  parameter int TRACK_N   = 2,
  parameter bit UNIFIED   = 1'b1
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        imem_stall_rnd,
  input  logic [DATA_W-1:0]           imem_rdata_rnd,
  input  logic [ADDR_W-1:0]           imem_addr,
  output logic                        imem_stall,
  output logic [DATA_W-1:0]           imem_data,
  input  logic                        dmem_stall_rnd,
  input  logic [DATA_W-1:0]           dmem_rdata_rnd,
  input  logic [ADDR_W-1:0]           dmem_addr,
  input  logic [DATA_W/8-1:0]         dmem_wmask,
  input  logic [DATA_W-1:0]           dmem_wdata,
  output logic                        dmem_stall,
  output logic [DATA_W-1:0]           dmem_rdata,
  input  logic [TRACK_N*ADDR_W-1:0]   track_addr,
  output logic [1:0]                  stall_sat
);

  localparam int NB   = calc_nb(DATA_W);
  localparam int WA_W = ADDR_W - 2;

  logic                            i_sat;
  logic                            d_sat;
  logic                            wr_commit;
  logic [TRACK_N-1:0]              ihit;
  logic [TRACK_N-1:0]              dhit;
  logic [TRACK_N-1:0][DATA_W-1:0]  data_q;
  logic [TRACK_N-1:0][DATA_W-1:0]  data_d;
  logic [TRACK_N-1:0][NB-1:0]      bvalid_q;
  logic [TRACK_N-1:0][NB-1:0]      bvalid_d;
  logic [DATA_W-1:0]               i_sel_data;
  logic [NB-1:0]                   i_sel_valid;
  logic [DATA_W-1:0]               d_sel_data;
  logic [NB-1:0]                   d_sel_valid;
  logic                            unused_bits;

  rvfi_stall_limiter #(.MAX_STALL(MAX_STALL)) u_imem_lim (
    .clock     (clock),
    .reset_n   (reset_n),
    .stall_rnd (imem_stall_rnd),
    .stall     (imem_stall),
    .sat       (i_sat)
  );

  rvfi_stall_limiter #(.MAX_STALL(MAX_STALL)) u_dmem_lim (
    .clock     (clock),
    .reset_n   (reset_n),
    .stall_rnd (dmem_stall_rnd),
    .stall     (dmem_stall),
    .sat       (d_sat)
  );

  assign stall_sat = {d_sat, i_sat};
  assign wr_commit = !dmem_stall && (|dmem_wmask);

  // Address bits [1:0] never take part in matching.
  assign unused_bits = ^{imem_addr, dmem_addr[1:0], track_addr};

  generate
    for (genvar i = 0; i < TRACK_N; i++) begin : g_entry
      logic [WA_W-1:0] tag;
      assign tag     = track_addr[i*ADDR_W+2 +: WA_W];
      assign dhit[i] = (dmem_addr[ADDR_W-1:2] == tag);
      assign ihit[i] = UNIFIED && (imem_addr[ADDR_W-1:2] == tag);

      // Every hitting entry takes the write, keeping duplicate tags coherent.
      for (genvar b = 0; b < NB; b++) begin : g_lane
        logic lane_wr;
        assign lane_wr             = wr_commit && dhit[i] && dmem_wmask[b];
        assign data_d[i][b*8 +: 8] = lane_wr ? dmem_wdata[b*8 +: 8]
                                             : data_q[i][b*8 +: 8];
        assign bvalid_d[i][b]      = bvalid_q[i][b] || lane_wr;
      end
    end
  endgenerate

  // NOTE: the shadow is reset because bvalid must read as empty right after
  // reset; data is cleared alongside it only to keep the store deterministic.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_q   <= '0;
      bvalid_q <= '0;
    end else begin
      data_q   <= data_d;
      bvalid_q <= bvalid_d;
    end
  end

  // Walk from the top so the lowest-index hit is the one left selected.
  always_comb begin
    i_sel_data  = '0;
    i_sel_valid = '0;
    d_sel_data  = '0;
    d_sel_valid = '0;
    for (int i = TRACK_N - 1; i >= 0; i--) begin
      if (ihit[i]) begin
        i_sel_data  = data_q[i];
        i_sel_valid = bvalid_q[i];
      end
      if (dhit[i]) begin
        d_sel_data  = data_q[i];
        d_sel_valid = bvalid_q[i];
      end
    end
  end

  generate
    for (genvar b = 0; b < NB; b++) begin : g_out_lane
      assign imem_data[b*8 +: 8]  = merge(i_sel_data[b*8 +: 8],
                                          imem_rdata_rnd[b*8 +: 8],
                                          i_sel_valid[b]);
      assign dmem_rdata[b*8 +: 8] = merge(d_sel_data[b*8 +: 8],
                                          dmem_rdata_rnd[b*8 +: 8],
                                          d_sel_valid[b]);
    end
  endgenerate

endmodule

// File: tb/tb_rvfi_mem_env.sv
// Scoreboard bench: a byte-addressed reference memory predicts every cycle's
// outputs for a unified MAX_STALL=4 env and a split never-stalling env.
module tb_rvfi_mem_env;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int NB   = 4;
  localparam int MAXS = 4;
  localparam int TN   = 2;
  localparam logic [AW-1:0] NT = 32'h0000_0400;

  typedef struct packed {
    logic          is;
    logic          ds;
    logic [1:0]    sat;
    logic [DW-1:0] id;
    logic [DW-1:0] dd;
    logic          a_is;
    logic          a_ds;
    logic [1:0]    a_sat;
    logic [DW-1:0] a_id;
    logic [DW-1:0] a_dd;
  } exp_t;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              imem_stall_rnd;
  logic [DW-1:0]     imem_rdata_rnd;
  logic [AW-1:0]     imem_addr;
  logic              dmem_stall_rnd;
  logic [DW-1:0]     dmem_rdata_rnd;
  logic [AW-1:0]     dmem_addr;
  logic [NB-1:0]     dmem_wmask;
  logic [DW-1:0]     dmem_wdata;
  logic [TN*AW-1:0]  track_addr;

  logic              imem_stall, dmem_stall;
  logic [DW-1:0]     imem_data, dmem_rdata;
  logic [1:0]        stall_sat;
  logic              alt_imem_stall, alt_dmem_stall;
  logic [DW-1:0]     alt_imem_data, alt_dmem_rdata;
  logic [1:0]        alt_stall_sat;

  always #5 clock = ~clock;

  rvfi_mem_env #(.ADDR_W(AW), .DATA_W(DW), .MAX_STALL(MAXS), .TRACK_N(TN),
                 .UNIFIED(1'b1)) u_dut (
    .clock(clock), .reset_n(reset_n),
    .imem_stall_rnd(imem_stall_rnd), .imem_rdata_rnd(imem_rdata_rnd),
    .imem_addr(imem_addr), .imem_stall(imem_stall), .imem_data(imem_data),
    .dmem_stall_rnd(dmem_stall_rnd), .dmem_rdata_rnd(dmem_rdata_rnd),
    .dmem_addr(dmem_addr), .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
    .dmem_stall(dmem_stall), .dmem_rdata(dmem_rdata),
    .track_addr(track_addr), .stall_sat(stall_sat)
  );

  rvfi_mem_env #(.ADDR_W(AW), .DATA_W(DW), .MAX_STALL(0), .TRACK_N(TN),
                 .UNIFIED(1'b0)) u_alt (
    .clock(clock), .reset_n(reset_n),
    .imem_stall_rnd(imem_stall_rnd), .imem_rdata_rnd(imem_rdata_rnd),
    .imem_addr(imem_addr), .imem_stall(alt_imem_stall), .imem_data(alt_imem_data),
    .dmem_stall_rnd(dmem_stall_rnd), .dmem_rdata_rnd(dmem_rdata_rnd),
    .dmem_addr(dmem_addr), .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
    .dmem_stall(alt_dmem_stall), .dmem_rdata(alt_dmem_rdata),
    .track_addr(track_addr), .stall_sat(alt_stall_sat)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  exp_t        sb[$];
  exp_t        last_e;
  bit          have_last = 0;
  int          run_i = 0;
  int          run_d = 0;
  logic [7:0]  mem [longint];
  logic [AW-1:0] trk [TN];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
  endtask

  // Reference model: bytes remembered per (instance, word, lane), readable
  // only at tracked words.
  function automatic bit tracked(input logic [AW-1:0] a);
    for (int i = 0; i < TN; i++) if (trk[i][AW-1:2] == a[AW-1:2]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic longint key_of(input int inst, input logic [AW-1:0] a, input int lane);
    return (longint'(inst) << 40) | (longint'(a[AW-1:2]) << 2) | longint'(lane);
  endfunction

  function automatic logic [DW-1:0] rd(input int inst, input logic [AW-1:0] a,
                                       input logic [DW-1:0] rnd, input bit use_shadow);
    logic [DW-1:0] r;
    r = rnd;
    if (use_shadow && tracked(a))
      for (int b = 0; b < NB; b++)
        if (mem.exists(key_of(inst, a, b))) r[b*8 +: 8] = mem[key_of(inst, a, b)];
    return r;
  endfunction

  function automatic void wr(input int inst);
    if (tracked(dmem_addr))
      for (int b = 0; b < NB; b++)
        if (dmem_wmask[b]) mem[key_of(inst, dmem_addr, b)] = dmem_wdata[b*8 +: 8];
  endfunction

  function automatic exp_t predict();
    exp_t e;
    bit   rst;
    rst     = reset_n;
    e.is    = !rst || (imem_stall_rnd && run_i < MAXS);
    e.ds    = !rst || (dmem_stall_rnd && run_d < MAXS);
    e.sat   = {rst && dmem_stall_rnd && !(run_d < MAXS),
               rst && imem_stall_rnd && !(run_i < MAXS)};
    e.id    = rd(0, imem_addr, imem_rdata_rnd, rst);
    e.dd    = rd(0, dmem_addr, dmem_rdata_rnd, rst);
    e.a_is  = !rst;
    e.a_ds  = !rst;
    e.a_sat = rst ? {dmem_stall_rnd, imem_stall_rnd} : 2'b00;
    e.a_id  = imem_rdata_rnd;
    e.a_dd  = rd(1, dmem_addr, dmem_rdata_rnd, rst);
    return e;
  endfunction

  // Apply the effect of the cycle that just ended at this rising edge.
  function automatic void advance();
    if (have_last && reset_n) begin
      run_i = last_e.is ? run_i + 1 : 0;
      run_d = last_e.ds ? run_d + 1 : 0;
      if (!last_e.ds && |dmem_wmask) wr(0);
      if (!last_e.a_ds && |dmem_wmask) wr(1);
    end
  endfunction

  task automatic step(input bit rst, input bit is, input logic [AW-1:0] ia,
                      input logic [DW-1:0] ir, input bit ds, input logic [AW-1:0] da,
                      input logic [DW-1:0] dr, input logic [NB-1:0] wm,
                      input logic [DW-1:0] wd);
    @(posedge clock);
    advance();
    #1;
    reset_n        = rst;
    imem_stall_rnd = is;
    imem_addr      = ia;
    imem_rdata_rnd = ir;
    dmem_stall_rnd = ds;
    dmem_addr      = da;
    dmem_rdata_rnd = dr;
    dmem_wmask     = wm;
    dmem_wdata     = wd;
    if (!rst) begin
      mem.delete();
      run_i = 0;
      run_d = 0;
    end
    last_e    = predict();
    have_last = 1'b1;
    sb.push_back(last_e);
  endtask

  function automatic logic [AW-1:0] raddr();
    logic [AW-1:0] pool [4];
    logic [AW-1:0] a;
    pool[0] = 32'h100; pool[1] = 32'h200; pool[2] = 32'h300; pool[3] = 32'h104;
    a       = pool[$urandom_range(0, 3)];
    a[1:0]  = 2'($urandom_range(0, 3));
    return a;
  endfunction

  // Monitor: compares whatever the DUTs present against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("imem_stall",     64'(imem_stall),     64'(e.is));
        check("dmem_stall",     64'(dmem_stall),     64'(e.ds));
        check("stall_sat",      64'(stall_sat),      64'(e.sat));
        check("imem_data",      64'(imem_data),      64'(e.id));
        check("dmem_rdata",     64'(dmem_rdata),     64'(e.dd));
        check("alt_imem_stall", 64'(alt_imem_stall), 64'(e.a_is));
        check("alt_dmem_stall", 64'(alt_dmem_stall), 64'(e.a_ds));
        check("alt_stall_sat",  64'(alt_stall_sat),  64'(e.a_sat));
        check("alt_imem_data",  64'(alt_imem_data),  64'(e.a_id));
        check("alt_dmem_rdata", 64'(alt_dmem_rdata), 64'(e.a_dd));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    trk[0]     = 32'h100;
    trk[1]     = 32'h200;
    track_addr = {trk[1], trk[0]};
    reset_n = 1'b0; imem_stall_rnd = 1'b0; imem_addr = NT; imem_rdata_rnd = '0;
    dmem_stall_rnd = 1'b0; dmem_addr = NT; dmem_rdata_rnd = '0;
    dmem_wmask = '0; dmem_wdata = '0;

    // Reset: stalls forced, no saturation, data passes rnd through.
    step(0, 1, 32'h100, 32'h1234_5678, 1, 32'h100, 32'h9ABC_DEF0, 4'hF, 32'hFFFF_FFFF);
    #1;
    check("rst_imem_stall", 64'(imem_stall), 64'd1);
    check("rst_dmem_stall", 64'(dmem_stall), 64'd1);
    check("rst_stall_sat",  64'(stall_sat),  64'd0);
    check("rst_dmem_rdata", 64'(dmem_rdata), 64'h9ABC_DEF0);
    step(0, 0, NT, 32'h0, 0, NT, 32'h0, 4'h0, 32'h0);

    // Stall bound: 1,1,1,1,0 repeating, saturation on the unstalled cycles.
    for (int k = 0; k < 10; k++) begin
      step(1, 1, NT, $urandom, 0, NT, $urandom, 4'h0, 32'h0);
      #1;
      check($sformatf("stall_bound_%0d", k), 64'(imem_stall), 64'(k % 5 != 4));
      check($sformatf("stall_sat_%0d", k),   64'(stall_sat[0]), 64'(k % 5 == 4));
    end

    // Partial write merge into a fresh entry.
    step(1, 0, NT, 32'h0, 0, 32'h100, 32'h0, 4'b0010, 32'h0000_AB00);
    step(1, 0, NT, 32'h0, 0, 32'h100, 32'h1122_3344, 4'h0, 32'h0);
    #1;
    check("partial_merge", 64'(dmem_rdata), 64'h1122_AB44);

    // Full write then read back with zero rnd.
    step(1, 0, NT, 32'h0, 0, 32'h100, 32'h0, 4'hF, 32'hDEAD_BEEF);
    step(1, 0, NT, 32'h0, 0, 32'h100, 32'h0, 4'h0, 32'h0);
    #1;
    check("write_then_read", 64'(dmem_rdata), 64'hDEAD_BEEF);

    // Stalled write to the other tracked word is dropped.
    step(1, 0, NT, 32'h0, 1, 32'h200, 32'h0, 4'hF, 32'h5555_5555);
    step(1, 0, NT, 32'h0, 0, 32'h200, 32'h7777_8888, 4'h0, 32'h0);
    #1;
    check("stalled_write_ignored", 64'(dmem_rdata), 64'h7777_8888);

    // Same-cycle store and fetch: fetch sees the old contents, then the new.
    step(0, 0, NT, 32'h0, 0, NT, 32'h0, 4'h0, 32'h0);
    step(1, 0, 32'h100, 32'h55AA_55AA, 0, 32'h100, 32'h0, 4'hF, 32'hCAFE_F00D);
    #1;
    check("same_cycle_fetch", 64'(imem_data), 64'h55AA_55AA);
    step(1, 0, 32'h102, 32'h0F0F_0F0F, 0, NT, 32'h0, 4'h0, 32'h0);
    #1;
    check("next_cycle_fetch", 64'(imem_data), 64'hCAFE_F00D);
    check("split_fetch_rnd",  64'(alt_imem_data), 64'h0F0F_0F0F);

    // Reset during a stall run clears the shadow and restarts the count.
    step(1, 0, NT, 32'h0, 1, 32'h100, 32'h0, 4'h0, 32'h0);
    step(0, 0, NT, 32'h0, 1, 32'h100, 32'h0, 4'h0, 32'h0);
    #1;
    check("mid_rst_dmem_stall", 64'(dmem_stall), 64'd1);
    check("mid_rst_stall_sat",  64'(stall_sat),  64'd0);
    for (int k = 0; k < 5; k++) begin
      step(1, 0, NT, 32'h0, 1, 32'h100, 32'h3C3C_3C3C, 4'h0, 32'h0);
      #1;
      check($sformatf("post_rst_stall_%0d", k), 64'(dmem_stall), 64'(k < 4));
      check($sformatf("post_rst_rdata_%0d", k), 64'(dmem_rdata), 64'h3C3C_3C3C);
    end

    // Randomised traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 49) != 0, $urandom_range(0, 9) < 6, raddr(), $urandom,
           $urandom_range(0, 9) < 5, raddr(), $urandom,
           ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0, $urandom);
    end

    @(negedge clock);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
